// File: rtl/hazard_control_unit_pkg.sv
// Shared types and constants for the ID/EX hazard control unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [3:0] OP_JAL  = 4'b0100;
  localparam logic [3:0] OP_JALR = 4'b0110;

  // Window down-counter; wide enough for the longest stall window (15).
  localparam int DCNT_W = 4;
  typedef logic [DCNT_W-1:0] dcnt_t;

  // The first cycle of a window is spent in IDLE, so the state only covers the rest.
  function automatic dcnt_t win_load(input int cycles);
    return dcnt_t'(cycles - 1);
  endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// ID/EX pipeline view of the hazard unit: stage fields in, control and event counts out.
interface hazard_control_unit_if #(
  parameter int REG_W = 4,
  parameter int OP_W  = 4,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [REG_W-1:0] ex_rd;
  logic             ex_memread;
  logic [OP_W-1:0]  ex_instop;
  logic             ex_branch;
  logic             ex_zero;

  logic             stall;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_bubble;
  logic             ifid_flush;
  logic             branch_taken;
  logic [CNT_W-1:0] stall_events;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_rd, ex_memread, ex_instop, ex_branch, ex_zero,
    input  stall, pc_write, ifid_write, idex_bubble, ifid_flush, branch_taken,
    input  stall_events, flush_events
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_rd, ex_memread, ex_instop, ex_branch, ex_zero,
    output stall, pc_write, ifid_write, idex_bubble, ifid_flush, branch_taken,
    output stall_events, flush_events
  );
endinterface

// File: rtl/hazard_control_unit_reg_compare.sv
// One source-vs-destination register match, gated by the source use flag.
module hazard_reg_compare
  import hazard_pkg::*;
#(
  parameter int REG_W       = 4,
  parameter int ZERO_REG_EN = 1
) (
  input  logic [REG_W-1:0] rs,
  input  logic             uses,
  input  logic [REG_W-1:0] rd,
  output logic             match
);

  // x0 is hardwired, so a load targeting it never produces a value to wait for.
  logic rd_zero;
  assign rd_zero = (ZERO_REG_EN != 0) && (rd == '0);
  assign match   = uses && (rs == rd) && !rd_zero;

endmodule

// File: rtl/hazard_control_unit.sv
// Load-use stall and branch/jump flush sequencer between ID and EX, with window counters.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int REG_W        = 4,
  parameter int OP_W         = 4,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int ZERO_REG_EN  = 1,
  parameter int CNT_W        = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  hazard_control_unit_if.slave bus
);

  localparam int NUM_SRC = 2;

  state_t state, state_nxt;
  dcnt_t  dcnt, dcnt_nxt;

  logic [NUM_SRC-1:0][REG_W-1:0] rs_vec;
  logic [NUM_SRC-1:0]            use_vec;
  logic [NUM_SRC-1:0]            match_vec;

  logic hazard, redirect;
  logic stall_start, flush_start;
  logic stall_o, pc_write_o, ifid_write_o, bubble_o, flush_o, taken_o;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  assign rs_vec  = {bus.id_rs2, bus.id_rs1};
  assign use_vec = {bus.id_uses_rs2, bus.id_uses_rs1};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_cmp
    hazard_reg_compare #(
      .REG_W      (REG_W),
      .ZERO_REG_EN(ZERO_REG_EN)
    ) u_cmp (
      .rs   (rs_vec[i]),
      .uses (use_vec[i]),
      .rd   (bus.ex_rd),
      .match(match_vec[i])
    );
  end

  assign hazard   = bus.ex_memread && (|match_vec);
  assign redirect = (bus.ex_branch && !bus.ex_zero) ||
                    (bus.ex_instop == OP_W'(OP_JAL)) ||
                    (bus.ex_instop == OP_W'(OP_JALR));

  always_comb begin
    state_nxt    = state;
    dcnt_nxt     = dcnt;
    stall_start  = 1'b0;
    flush_start  = 1'b0;
    stall_o      = 1'b0;
    pc_write_o   = 1'b1;
    ifid_write_o = 1'b1;
    bubble_o     = 1'b0;
    flush_o      = 1'b0;
    taken_o      = 1'b0;
    if (reset_n) begin
      unique case (state)
        IDLE, STALL: begin
          // A redirect outranks a stall: the stalled instruction is on the wrong path.
          if (redirect) begin
            taken_o     = 1'b1;
            flush_o     = 1'b1;
            bubble_o    = 1'b1;
            flush_start = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_nxt = FLUSH;
              dcnt_nxt  = win_load(FLUSH_CYCLES);
            end else begin
              state_nxt = IDLE;
            end
          end else if (state == STALL) begin
            stall_o      = 1'b1;
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            bubble_o     = 1'b1;
            dcnt_nxt     = dcnt - dcnt_t'(1);
            if (dcnt == dcnt_t'(1)) state_nxt = IDLE;
          end else if (hazard) begin
            stall_o      = 1'b1;
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            bubble_o     = 1'b1;
            stall_start  = 1'b1;
            if (LOAD_LAT > 1) begin
              state_nxt = STALL;
              dcnt_nxt  = win_load(LOAD_LAT);
            end
          end
        end
        FLUSH: begin
          // Instructions behind a redirect are dead, so hazards here are ignored.
          flush_o  = 1'b1;
          bubble_o = 1'b1;
          dcnt_nxt = dcnt - dcnt_t'(1);
          if (dcnt == dcnt_t'(1)) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      dcnt      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
      if (stall_start && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_start && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign bus.stall        = stall_o;
  assign bus.pc_write     = pc_write_o;
  assign bus.ifid_write   = ifid_write_o;
  assign bus.idex_bubble  = bubble_o;
  assign bus.ifid_flush   = flush_o;
  assign bus.branch_taken = taken_o;
  assign bus.stall_events = stall_cnt;
  assign bus.flush_events = flush_cnt;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench: three parameterisations of hazard_control_unit driven with shared stimulus.
module tb_hazard_control_unit;

  logic clock = 1'b0;
  logic reset_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  // {stall, pc_write, ifid_write, idex_bubble, ifid_flush, branch_taken}
  localparam logic [5:0] IDLE_V  = 6'b011000;
  localparam logic [5:0] STALL_V = 6'b100100;
  localparam logic [5:0] REDIR_V = 6'b011111;
  localparam logic [5:0] FLUSH_V = 6'b011110;

  hazard_control_unit_if #(.REG_W(4), .OP_W(4), .CNT_W(16)) bus_a ();
  hazard_control_unit_if #(.REG_W(4), .OP_W(4), .CNT_W(16)) bus_b ();
  hazard_control_unit_if #(.REG_W(4), .OP_W(4), .CNT_W(2))  bus_c ();

  hazard_control_unit #(.LOAD_LAT(2), .FLUSH_CYCLES(2), .ZERO_REG_EN(1), .CNT_W(16))
    u_a (.clock(clock), .reset_n(reset_n), .bus(bus_a));
  hazard_control_unit #(.LOAD_LAT(4), .FLUSH_CYCLES(2), .ZERO_REG_EN(1), .CNT_W(16))
    u_b (.clock(clock), .reset_n(reset_n), .bus(bus_b));
  hazard_control_unit #(.LOAD_LAT(1), .FLUSH_CYCLES(1), .ZERO_REG_EN(0), .CNT_W(2))
    u_c (.clock(clock), .reset_n(reset_n), .bus(bus_c));

  logic [5:0] ctl_a, ctl_b, ctl_c;
  assign ctl_a = {bus_a.stall, bus_a.pc_write, bus_a.ifid_write,
                  bus_a.idex_bubble, bus_a.ifid_flush, bus_a.branch_taken};
  assign ctl_b = {bus_b.stall, bus_b.pc_write, bus_b.ifid_write,
                  bus_b.idex_bubble, bus_b.ifid_flush, bus_b.branch_taken};
  assign ctl_c = {bus_c.stall, bus_c.pc_write, bus_c.ifid_write,
                  bus_c.idex_bubble, bus_c.ifid_flush, bus_c.branch_taken};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic [3:0] rs1, input logic u1, input logic [3:0] rs2,
                        input logic u2, input logic [3:0] rd, input logic mr,
                        input logic [3:0] op, input logic br, input logic z);
    bus_a.id_rs1 = rs1; bus_a.id_uses_rs1 = u1; bus_a.id_rs2 = rs2; bus_a.id_uses_rs2 = u2;
    bus_a.ex_rd = rd; bus_a.ex_memread = mr; bus_a.ex_instop = op;
    bus_a.ex_branch = br; bus_a.ex_zero = z;
    bus_b.id_rs1 = rs1; bus_b.id_uses_rs1 = u1; bus_b.id_rs2 = rs2; bus_b.id_uses_rs2 = u2;
    bus_b.ex_rd = rd; bus_b.ex_memread = mr; bus_b.ex_instop = op;
    bus_b.ex_branch = br; bus_b.ex_zero = z;
    bus_c.id_rs1 = rs1; bus_c.id_uses_rs1 = u1; bus_c.id_rs2 = rs2; bus_c.id_uses_rs2 = u2;
    bus_c.ex_rd = rd; bus_c.ex_memread = mr; bus_c.ex_instop = op;
    bus_c.ex_branch = br; bus_c.ex_zero = z;
    #1;
  endtask

  task automatic idle_in();
    set_in(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic lu_in();
    set_in(4'd5, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic br_in(input logic z);
    set_in(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, z);
  endtask

  initial begin
    // Reset held with a live load-use pattern on the inputs
    reset_n = 1'b0;
    lu_in();
    next(); next(); lu_in();
    chk("rst_ctl_a", ctl_a, IDLE_V);
    chk("rst_ctl_c", ctl_c, IDLE_V);
    chk("rst_stall_ev_a", bus_a.stall_events, 0);
    chk("rst_flush_ev_a", bus_a.flush_events, 0);
    reset_n = 1'b1; idle_in();
    chk("rel_ctl_a", ctl_a, IDLE_V);

    // Load-use: A stalls 2 cycles, B 4, C 1
    next(); lu_in();
    chk("lu1_a", ctl_a, STALL_V);
    chk("lu1_b", ctl_b, STALL_V);
    chk("lu1_c", ctl_c, STALL_V);
    next(); idle_in();
    chk("lu2_a", ctl_a, STALL_V);
    chk("lu2_b", ctl_b, STALL_V);
    chk("lu2_c", ctl_c, IDLE_V);
    next(); idle_in();
    chk("lu3_a", ctl_a, IDLE_V);
    chk("lu3_b", ctl_b, STALL_V);
    chk("lu3_stall_ev_a", bus_a.stall_events, 1);
    next(); idle_in();
    chk("lu4_b", ctl_b, STALL_V);
    next(); idle_in();
    chk("lu5_b", ctl_b, IDLE_V);
    chk("lu5_stall_ev_b", bus_b.stall_events, 1);

    // Load into x0: ignored by A (zero-reg exclusion), stalls C
    next(); set_in(4'd0, 1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0);
    chk("zr_a", ctl_a, IDLE_V);
    chk("zr_c", ctl_c, STALL_V);
    next(); idle_in();
    chk("zr_stall_ev_a", bus_a.stall_events, 1);
    chk("zr_stall_ev_c", bus_c.stall_events, 2);
    chk("zr_after_c", ctl_c, IDLE_V);

    // Taken branch: 1 redirect cycle, flush window 2 on A, 1 on C
    next(); br_in(1'b0);
    chk("br1_a", ctl_a, REDIR_V);
    chk("br1_c", ctl_c, REDIR_V);
    next(); idle_in();
    chk("br2_a", ctl_a, FLUSH_V);
    chk("br2_c", ctl_c, IDLE_V);
    chk("br2_flush_ev_a", bus_a.flush_events, 1);
    next(); idle_in();
    chk("br3_a", ctl_a, IDLE_V);
    // Not-taken branch
    next(); br_in(1'b1);
    chk("nt_a", ctl_a, IDLE_V);
    next(); idle_in();
    chk("nt_flush_ev_a", bus_a.flush_events, 1);

    // JALR with a concurrent load-use: redirect wins; hazard then ignored in FLUSH
    next(); set_in(4'd5, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 4'b0110, 1'b0, 1'b0);
    chk("sim1_a", ctl_a, REDIR_V);
    next(); lu_in();
    chk("sim2_a", ctl_a, FLUSH_V);
    chk("sim2_flush_ev_a", bus_a.flush_events, 2);
    chk("sim2_stall_ev_a", bus_a.stall_events, 1);
    next(); idle_in();
    chk("sim3_a", ctl_a, IDLE_V);
    chk("sim3_stall_ev_a", bus_a.stall_events, 1);

    // Preemption: B in a 4-cycle stall, branch resolves in its second cycle
    next(); lu_in();
    chk("pre1_b", ctl_b, STALL_V);
    next(); br_in(1'b0);
    chk("pre2_b", ctl_b, REDIR_V);
    chk("pre2_a", ctl_a, REDIR_V);
    next(); idle_in();
    chk("pre3_b", ctl_b, FLUSH_V);
    chk("pre3_stall_ev_b", bus_b.stall_events, 2);
    chk("pre3_flush_ev_b", bus_b.flush_events, 3);
    next(); idle_in();
    chk("pre4_b", ctl_b, IDLE_V);

    // Reset during FLUSH
    next(); br_in(1'b0);
    chk("rf1_a", ctl_a, REDIR_V);
    next(); reset_n = 1'b0; idle_in();
    chk("rf2_a", ctl_a, IDLE_V);
    chk("rf2_b", ctl_b, IDLE_V);
    next(); reset_n = 1'b1; idle_in();
    chk("rf3_stall_ev_a", bus_a.stall_events, 0);
    chk("rf3_flush_ev_a", bus_a.flush_events, 0);
    chk("rf3_flush_ev_b", bus_b.flush_events, 0);
    chk("rf3_a", ctl_a, IDLE_V);
    next(); idle_in();
    chk("rf4_a", ctl_a, IDLE_V);

    // Reset during B's stall: no leftover stall cycles after release
    next(); lu_in();
    chk("rs1_b", ctl_b, STALL_V);
    next(); reset_n = 1'b0; idle_in();
    chk("rs2_b", ctl_b, IDLE_V);
    chk("rs2_a", ctl_a, IDLE_V);
    next(); reset_n = 1'b1; idle_in();
    chk("rs3_b", ctl_b, IDLE_V);
    next(); idle_in();
    chk("rs4_b", ctl_b, IDLE_V);
    chk("rs4_stall_ev_b", bus_b.stall_events, 0);

    // Separate stall windows: C saturates at 3, A counts every back-to-back window
    for (int k = 1; k <= 5; k++) begin
      next(); lu_in();
      chk("sat_ctl_c", ctl_c, STALL_V);
      chk("sat_ctl_a", ctl_a, STALL_V);
      next(); idle_in();
      chk("sat_cnt_c", bus_c.stall_events, (k > 3) ? 3 : k);
      chk("sat_cnt_a", bus_a.stall_events, k);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
